// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Merges the instruction-fetch port (imem) and the load/store port (dmem)
//   onto one shared valid/ready memory port. Data accesses win arbitration.
//   A bounded streak counter guarantees that a waiting fetch is eventually
//   served. A response timeout aborts a transaction whose slave never
//   answers: the requester gets 32'hDEADBEEF and bus_err_o pulses.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   imem_* / dmem_*           requester ports (valid/addr/wdata/we in,
//                             ready/rdata out; ready is a 1-cycle pulse)
//   mem_valid_o, mem_addr_o,
//   mem_wdata_o, mem_we_o     registered shared-port request
//   mem_ready_i, mem_rdata_i  shared-port completion and read data
//   bus_err_o                 one-cycle pulse on timeout abort
module mem_arbiter #(
    parameter int RISCV_ADDR_WIDTH = 32,
    parameter int RISCV_WORD_WIDTH = 32,
    parameter int MAX_D_STREAK     = 4,
    parameter int TIMEOUT          = 255
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        imem_valid_i,
    output logic                        imem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]                  imem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] imem_rdata_o,

    input  logic                        dmem_valid_i,
    output logic                        dmem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] dmem_wdata_i,
    input  logic [3:0]                  dmem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] dmem_rdata_o,

    output logic                        mem_valid_o,
    input  logic                        mem_ready_i,
    output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]                  mem_we_o,
    input  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i,

    output logic                        bus_err_o
);

    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [CW-1:0] TO_VAL     = CW'(TIMEOUT);
    localparam logic [RISCV_WORD_WIDTH-1:0] ERR_WORD = RISCV_WORD_WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] streak;
    logic [CW-1:0] wait_cnt;

    logic grant_i, grant_d;
    logic done, abort, finish;
    logic timeout_hit;

    // TIMEOUT == 0 disables the abort path entirely.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_VAL);

    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (dmem_valid_i && ((streak < STREAK_MAX) || !imem_valid_i)) begin
                    grant_d = 1'b1;
                    state_n = BUSY_D;
                end else if (imem_valid_i) begin
                    grant_i = 1'b1;
                    state_n = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // A completion in the timeout cycle takes precedence.
                if (mem_ready_i)      done  = 1'b1;
                else if (timeout_hit) abort = 1'b1;
                if (done || abort)    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A completion coinciding with reset must not reach the requester.
    assign finish       = (done || abort) && !rst;
    assign imem_ready_o = finish && (state == BUSY_I);
    assign dmem_ready_o = finish && (state == BUSY_D);
    assign imem_rdata_o = imem_ready_o ? (done ? mem_rdata_i : ERR_WORD) : '0;
    assign dmem_rdata_o = dmem_ready_o ? (done ? mem_rdata_i : ERR_WORD) : '0;
    assign bus_err_o    = abort && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            wait_cnt    <= '0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= '0;
        end else begin
            state <= state_n;

            if (grant_d) begin
                mem_valid_o <= 1'b1;
                mem_addr_o  <= dmem_addr_i;
                mem_wdata_o <= dmem_wdata_i;
                mem_we_o    <= dmem_we_i;
                wait_cnt    <= '0;
            end else if (grant_i) begin
                mem_valid_o <= 1'b1;
                mem_addr_o  <= imem_addr_i;
                mem_wdata_o <= imem_wdata_i;
                mem_we_o    <= imem_we_i;
                wait_cnt    <= '0;
            end else if (state != IDLE) begin
                if (done || abort) mem_valid_o <= 1'b0;
                else               wait_cnt    <= wait_cnt + 1'b1;
            end

            // Streak only counts D grants that made a waiting fetch wait.
            if (state == IDLE) begin
                if (grant_i || !imem_valid_i)
                    streak <= '0;
                else if (grant_d && (streak < STREAK_MAX))
                    streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-into-one memory arbiter downstream of the core's instruction and data memory interfaces. It merges the fetch port (imem) and the load/store port (dmem) onto a single shared memory port using the same valid/ready protocol. Data accesses have priority, with a bounded streak so fetch is never starved. A response timeout keeps the core from hanging on a dead slave.

## Interface
- RISCV_ADDR_WIDTH, 32, address width of all ports
- RISCV_WORD_WIDTH, 32, data width of all ports
- MAX_D_STREAK, 4, max consecutive dmem grants while imem is waiting
- TIMEOUT, 255, cycles without mem_ready_i before abort; 0 disables
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- imem_valid_i / dmem_valid_i  in  1  request from fetch / LSU, held until own ready
- imem_ready_o / dmem_ready_o  out  1  one-cycle completion pulse to requester
- imem_addr_i / dmem_addr_i  in  RISCV_ADDR_WIDTH  request address
- imem_wdata_i / dmem_wdata_i  in  RISCV_WORD_WIDTH  write data
- imem_we_i / dmem_we_i  in  4  byte write enables; 0 = read
- imem_rdata_o / dmem_rdata_o  out  RISCV_WORD_WIDTH  read data, valid only with own ready
- mem_valid_o  out  1  shared-port request
- mem_ready_i  in  1  shared-port completion
- mem_addr_o  out  RISCV_ADDR_WIDTH  shared-port address
- mem_wdata_o  out  RISCV_WORD_WIDTH  shared-port write data
- mem_we_o  out  4  shared-port byte enables
- mem_rdata_i  in  RISCV_WORD_WIDTH  shared-port read data
- bus_err_o  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, grant decision:
  - Grant D if dmem_valid_i and (streak < MAX_D_STREAK or !imem_valid_i).
  - Otherwise grant I if imem_valid_i.
  - Otherwise stay in IDLE.
- Grant cycle: latch the winner's addr/wdata/we into the mem_* output registers, set mem_valid_o, and move to BUSY_x.
- Streak counter:
  - Increments, saturating at MAX_D_STREAK, on a D grant made while imem_valid_i is high.
  - Cleared on any I grant, and in IDLE whenever imem_valid_i is low.
- BUSY_x, completion: when mem_ready_i is high, drive x_ready_o = 1 and x_rdata_o = mem_rdata_i combinationally in that cycle. Then clear mem_valid_o and return to IDLE.
- BUSY_x, timeout: if the wait counter reaches TIMEOUT with mem_ready_i still low:
  - Pulse x_ready_o with x_rdata_o = 32'hDEADBEEF and pulse bus_err_o.
  - Clear mem_valid_o and return to IDLE.
  - A mem_ready_i arriving in the same cycle wins: normal completion, no bus_err_o.
- Rdata outputs read 0 whenever their ready output is low.
- The non-granted port's ready stays 0.
- Requester dropping valid mid-transaction: the transaction still completes and the ready pulse is still issued. Downstream accesses are never aborted, except by timeout.
- Both requesters keeping valid high after their ready: treated as a new request at the next IDLE sample.

## Timing
- Reset values: mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, imem_ready_o=0, dmem_ready_o=0, imem_rdata_o=0, dmem_rdata_o=0, bus_err_o=0. State is IDLE, streak=0, wait counter=0.
- Request seen in IDLE at cycle N → mem_valid_o high from cycle N+1.
  - With a zero-wait slave (mem_ready_i high at N+1), the requester's ready fires at N+1.
  - IDLE again at N+2.
  - Minimum 2 cycles per transaction; zero idle cycles forced between back-to-back grants beyond that.
- mem_addr_o, mem_wdata_o and mem_we_o are stable for the whole time mem_valid_o is high.
- Wait counter: cleared on grant, increments each BUSY cycle with mem_ready_i low. Abort fires in the cycle the count equals TIMEOUT, i.e. TIMEOUT+1 cycles after mem_valid_o rises.
- Reset mid-transaction: mem_valid_o is low after the next edge. A mem_ready_i coinciding with rst produces no ready pulse.

## Test plan
- Single imem read, addr 0x100, mem_ready_i asserted 1 cycle after mem_valid_o, mem_rdata_i=0x00000013 → imem_ready_o pulses once with rdata 0x13; mem_we_o=0; dmem_ready_o stays 0.
- imem and dmem valid in the same cycle, dmem write addr 0x2000, we=4'b1111, wdata 0xCAFEBABE → dmem is served first with mem_* = those values, then imem; total 4 cycles at zero wait.
- dmem held valid continuously with imem waiting, MAX_D_STREAK=4 → exactly 4 dmem grants, then 1 imem grant, then dmem resumes.
- Slave never ready, TIMEOUT=255, dmem read → at cycle 256 after mem_valid_o rises: dmem_ready_o=1, dmem_rdata_o=0xDEADBEEF, bus_err_o=1 for one cycle; then mem_valid_o=0.
- mem_ready_i arrives exactly in the timeout cycle → normal completion with mem_rdata_i, bus_err_o=0.
- rst asserted while in BUSY_I with mem_ready_i high → no imem_ready_o pulse; all outputs 0 after the edge; the next imem request is granted normally.
